ram_sync_fill: RTL and testbench
================================

Name: ram_sync_fill

Overview:
- Parametrised, clocked single-port RAM. It is the next generation of the 128x32 asynchronous data/instruction RAM.
- Replaces the bidirectional data bus with separate write-data and read-data ports, and adds byte-lane write enables and a registered 1-cycle read.
- Replaces the level-triggered preload with a multi-cycle fill sequencer (start/busy/done handshake, selectable pattern).
- Used as instruction or data memory behind the pipeline's memory stage.

Parameters:
DATA_WIDTH  32  word width in bits; must be a multiple of 8
ADDR_WIDTH  7   address bits
DEPTH       128 implemented words; must be <= 2**ADDR_WIDTH

Ports:
clock       input   1              rising-edge clock
reset       input   1              synchronous, active-high reset
req_valid   input   1              access request this cycle
req_ready   output  1              request accepted when req_valid and req_ready
req_we      input   1              0: read, 1: write
req_addr    input   ADDR_WIDTH     word address
req_wdata   input   DATA_WIDTH     write data
req_be      input   DATA_WIDTH/8   byte-lane write enables; bit i gates bits [8i+7:8i]
rd_valid    output  1              rd_data valid (1-cycle pulse per accepted read)
rd_data     output  DATA_WIDTH     read data
addr_err    output  1              1-cycle pulse: accepted access had req_addr >= DEPTH
fill_start  input   1              start fill sequence (sampled in IDLE only)
fill_mode   input   2              0: zero, 1: index, 2: fill_value, 3: index + fill_value
fill_value  input   DATA_WIDTH     fill constant/offset, latched at fill start
busy        output  1              fill in progress
fill_done   output  1              1-cycle pulse after the last fill write

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous, active-high (reset), sampled on the rising edge.
- Reset values: state=IDLE, rd_valid=0, rd_data=0, addr_err=0, busy=0, fill_done=0. req_ready=0 while reset is high.
- Reset does not clear memory contents.
- States:
  - IDLE: req_ready=1, busy=0.
  - FILL: req_ready=0, busy=1.
- Transitions:
  - IDLE -> FILL on fill_start. That edge latches fill_mode and fill_value and clears the fill counter to 0. A request accepted on the same edge is executed normally.
  - FILL writes word[cnt] = pattern(cnt) every cycle, then increments cnt. Byte enables are ignored (full-word writes).
  - FILL -> IDLE on the edge that writes cnt=DEPTH-1. fill_done=1 for the following cycle. busy drops in that same cycle.
  - A full fill takes exactly DEPTH cycles of busy.
- Patterns, all truncated/zero-extended to DATA_WIDTH:
  - mode 0: 0
  - mode 1: cnt
  - mode 2: fill_value
  - mode 3: cnt + fill_value (modulo 2**DATA_WIDTH)
- fill_start while busy is ignored. Changing fill_mode or fill_value during FILL has no effect.
- Reset mid-fill: returns to IDLE, no fill_done pulse. Words already written keep their values; the rest are unchanged.
- Write (accepted, req_we=1, addr < DEPTH): on the edge, each enabled lane is updated and disabled lanes are kept. rd_valid stays 0.
- Read (accepted, req_we=0, addr < DEPTH): rd_data = word[addr] and rd_valid=1 in the next cycle (latency 1).
  - rd_data holds its value until the next accepted read.
  - A read immediately after a write to the same address returns the new data.
- Out of range (addr >= DEPTH):
  - Write: memory unchanged.
  - Read: rd_data=0 with rd_valid=1.
  - Both cases: addr_err pulses in the cycle after acceptance.
- Back-to-back accesses: one per cycle, no bubbles.

Test Plan:
- Reset, then fill_start with mode 1, default params -> busy high for exactly 128 cycles, then fill_done pulses once. Reads of addr 0, 5, 127 return 0x00000000, 0x00000005, 0x0000007F.
- Write 0xDEADBEEF to addr 12 with be=4'b1111. Then write 0x00001414 to addr 12 with be=4'b0011. Then read addr 12 -> rd_valid one cycle after the read is accepted, rd_data=0xDEAD1414.
- Mode 3 with fill_value=0x100 -> addr 0 reads 0x100, addr 127 reads 0x17F. Then start mode 0 and assert reset at fill cycle 10 -> words 0..9 read 0, word 10 reads 0x10A, fill_done never pulses, req_ready=1 after reset.
- Instance with DEPTH=100, ADDR_WIDTH=7:
  - Read addr 120 -> rd_data=0, addr_err pulses.
  - Write addr 110 -> addr_err pulses, memory unchanged.
  - Fill completes in 100 cycles.
- Same-edge fill_start and write to addr 3 of 0xAAAA5555 in IDLE -> write executes, fill (mode 2, fill_value=0x41) then overwrites, addr 3 reads 0x41. req_valid during busy -> req_ready=0, request not accepted. fill_start during busy -> ignored.
- Back-to-back reads of addr 1, 2, 3 on consecutive cycles after a mode 1 fill -> rd_valid high for 3 consecutive cycles with rd_data 1, 2, 3.

Source files
------------

// File: rtl/ram_sync_fill.sv
// Clocked single-port RAM with byte-lane writes, registered 1-cycle reads and a
// multi-cycle fill sequencer that writes one pattern word per cycle while busy.
module ram_sync_fill #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_be,
  output logic                      rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      addr_err,
  input  logic                      fill_start,
  input  logic [1:0]                fill_mode,
  input  logic [DATA_WIDTH-1:0]     fill_value,
  output logic                      busy,
  output logic                      fill_done
);

  localparam int                    NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_e;

  typedef enum logic [1:0] {
    FILL_ZERO   = 2'd0,
    FILL_INDEX  = 2'd1,
    FILL_CONST  = 2'd2,
    FILL_OFFSET = 2'd3
  } fill_mode_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  fill_mode_e              mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   value_q, value_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    addr_err_q;
  logic                    fill_done_q;

  logic                    accept;
  logic                    in_range;
  logic                    req_wr;
  logic                    fill_we;
  logic                    last_fill;
  logic [DATA_WIDTH-1:0]   fill_word;

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign busy      = (state_q == ST_FILL);
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_L;
  assign req_wr    = accept && req_we && in_range;
  // An edge with reset high must not complete the in-flight fill write.
  assign fill_we   = (state_q == ST_FILL) && !reset;
  assign last_fill = (state_q == ST_FILL) && (cnt_q == LAST_IDX);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    value_d = value_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          mode_d  = fill_mode_e'(fill_mode);
          value_d = fill_value;
        end
      end
      ST_FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fill_word = '0;
    case (mode_q)
      FILL_ZERO:   fill_word = '0;
      FILL_INDEX:  fill_word = DATA_WIDTH'(cnt_q);
      FILL_CONST:  fill_word = value_q;
      FILL_OFFSET: fill_word = DATA_WIDTH'(cnt_q) + value_q;
      default:     fill_word = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= FILL_ZERO;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      value_q <= value_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive reset and map onto plain RAM.
  always_ff @(posedge clock) begin
    if (fill_we) begin
      mem_q[cnt_q] <= fill_word;
    end else if (req_wr) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (req_be[i]) mem_q[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      addr_err_q  <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      rd_valid_q  <= accept && !req_we;
      addr_err_q  <= accept && !in_range;
      fill_done_q <= last_fill;
      // rd_data only moves on an accepted read and holds otherwise.
      if (accept && !req_we) rd_data_q <= in_range ? mem_q[req_addr] : '0;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign addr_err  = addr_err_q;
  assign fill_done = fill_done_q;

endmodule

// File: tb/tb_ram_sync_fill.sv
// Bench for ram_sync_fill: a full-depth instance and a DEPTH=100 instance share
// stimulus, selected by sel; reads are scored through an expected-data queue.
module tb_ram_sync_fill;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        fill_start = 1'b0;
  logic [1:0]  fill_mode = '0;
  logic [31:0] fill_value = '0;

  logic        a_req_valid, a_fill_start, b_req_valid, b_fill_start;
  logic        a_req_ready, a_rd_valid, a_addr_err, a_busy, a_fill_done;
  logic        b_req_ready, b_rd_valid, b_addr_err, b_busy, b_fill_done;
  logic [31:0] a_rd_data, b_rd_data;

  logic        req_ready_m, rd_valid_m, addr_err_m, busy_m, fill_done_m;
  logic [31:0] rd_data_m;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  sb_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign a_req_valid  = req_valid & ~sel;
  assign b_req_valid  = req_valid & sel;
  assign a_fill_start = fill_start & ~sel;
  assign b_fill_start = fill_start & sel;

  assign req_ready_m = sel ? b_req_ready : a_req_ready;
  assign rd_valid_m  = sel ? b_rd_valid  : a_rd_valid;
  assign rd_data_m   = sel ? b_rd_data   : a_rd_data;
  assign addr_err_m  = sel ? b_addr_err  : a_addr_err;
  assign busy_m      = sel ? b_busy      : a_busy;
  assign fill_done_m = sel ? b_fill_done : a_fill_done;

  ram_sync_fill dut_a (
    .clock      (clk),
    .reset      (rst),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rd_valid   (a_rd_valid),
    .rd_data    (a_rd_data),
    .addr_err   (a_addr_err),
    .fill_start (a_fill_start),
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
    .busy       (a_busy),
    .fill_done  (a_fill_done)
  );

  ram_sync_fill #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .DEPTH(100)) dut_b (
    .clock      (clk),
    .reset      (rst),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rd_valid   (b_rd_valid),
    .rd_data    (b_rd_data),
    .addr_err   (b_addr_err),
    .fill_start (b_fill_start),
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
    .busy       (b_busy),
    .fill_done  (b_fill_done)
  );

  // Read-data scoreboard: each rd_valid pops one entry and must land on its due cycle.
  always @(negedge clk) begin
    if (!rst && ((sel ? a_rd_valid : b_rd_valid) === 1'b1)) begin
      errors++;
      $display("FAIL rd_valid_unselected: unselected instance raised rd_valid at cycle %0d", cyc);
    end
    if (rd_valid_m === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid with data %h at cycle %0d, no read outstanding", rd_data_m, cyc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (rd_data_m !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL rd_data: got %h at cycle %0d, expected %h at cycle %0d", rd_data_m, cyc, e.data, e.due);
        end
      end
    end
  end

  task automatic do_read(input logic [6:0] addr, input logic [31:0] exp);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_be = '0; req_wdata = '0;
    if (req_ready_m === 1'b1) sb.push_back('{data: exp, due: cyc + 1});
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_be = be; req_wdata = data;
  endtask

  task automatic end_req;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads still outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_fill(input logic [1:0] mode, input logic [31:0] val, input int depth,
                         input bit with_write);
    int n = 0;
    int done_seen = 0;
    @(negedge clk);
    checks++;
    if (busy_m !== 1'b0) begin
      errors++;
      $display("FAIL fill_pre_busy: busy=%b, expected 0", busy_m);
    end
    fill_start = 1'b1; fill_mode = mode; fill_value = val;
    if (with_write) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd3; req_wdata = 32'hAAAA5555; req_be = 4'hF;
    end
    @(negedge clk);
    fill_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    fill_mode = ~mode; fill_value = ~val;
    while (busy_m === 1'b1 && n < 400) begin
      n++;
      if (fill_done_m === 1'b1) done_seen++;
      if (n == 5) fill_start = 1'b1;
      if (n == 6) fill_start = 1'b0;
      if (n == 10) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
        checks++;
        if (req_ready_m !== 1'b0) begin
          errors++;
          $display("FAIL ready_while_busy: req_ready=%b, expected 0", req_ready_m);
        end
      end
      if (n == 11) req_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n != depth) begin
      errors++;
      $display("FAIL fill_busy_cycles: busy for %0d cycles, expected %0d", n, depth);
    end
    checks++;
    if (fill_done_m !== 1'b1 || done_seen != 0) begin
      errors++;
      $display("FAIL fill_done_pulse: done=%b early_pulses=%0d, expected done=1 early_pulses=0",
               fill_done_m, done_seen);
    end
    @(negedge clk);
    checks++;
    if (fill_done_m !== 1'b0) begin
      errors++;
      $display("FAIL fill_done_width: fill_done=%b one cycle later, expected 0", fill_done_m);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready_m, rd_valid_m, addr_err_m, busy_m, fill_done_m} !== 5'b0 || rd_data_m !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: ready/rv/err/busy/done=%b rd_data=%h, expected 00000 and 0",
               {req_ready_m, rd_valid_m, addr_err_m, busy_m, fill_done_m}, rd_data_m);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready_m !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: req_ready=%b, expected 1", req_ready_m);
    end
  endtask

  task automatic test_fill_index;
    do_fill(2'd1, 32'h0, 128, 1'b0);
    do_read(7'd0, 32'h0);
    do_read(7'd5, 32'h5);
    do_read(7'd127, 32'h7F);
    end_req;
    drain;
  endtask

  task automatic test_back_to_back;
    do_read(7'd1, 32'h1);
    do_read(7'd2, 32'h2);
    do_read(7'd3, 32'h3);
    end_req;
    drain;
  endtask

  task automatic test_byte_enable;
    do_write(7'd12, 32'hDEADBEEF, 4'b1111);
    do_write(7'd12, 32'h00001414, 4'b0011);
    do_read(7'd12, 32'hDEAD1414);
    do_write(7'd12, 32'h12345678, 4'b1111);
    do_read(7'd12, 32'h12345678);
    do_write(7'd12, 32'hCAFEF00D, 4'b1000);
    do_read(7'd12, 32'hCA345678);
    end_req;
    drain;
    do_write(7'd20, 32'h0, 4'b1111);
    end_req;
    checks++;
    if (rd_valid_m !== 1'b0 || rd_data_m !== 32'hCA345678 || addr_err_m !== 1'b0) begin
      errors++;
      $display("FAIL rd_data_hold: rd_valid=%b rd_data=%h addr_err=%b, expected 0 CA345678 0",
               rd_valid_m, rd_data_m, addr_err_m);
    end
  endtask

  task automatic test_fill_offset_reset;
    do_fill(2'd3, 32'h100, 128, 1'b0);
    do_read(7'd0, 32'h100);
    do_read(7'd127, 32'h17F);
    end_req;
    drain;
    @(negedge clk);
    fill_start = 1'b1; fill_mode = 2'd0; fill_value = 32'h0;
    @(negedge clk);
    fill_start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy_m !== 1'b1) begin
      errors++;
      $display("FAIL midfill_busy: busy=%b at fill cycle 10, expected 1", busy_m);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy_m !== 1'b0 || fill_done_m !== 1'b0 || req_ready_m !== 1'b1) begin
      errors++;
      $display("FAIL midfill_reset: busy=%b done=%b ready=%b, expected 0 0 1",
               busy_m, fill_done_m, req_ready_m);
    end
    @(negedge clk);
    checks++;
    if (fill_done_m !== 1'b0) begin
      errors++;
      $display("FAIL midfill_no_done: fill_done=%b after reset, expected 0", fill_done_m);
    end
    for (int i = 0; i < 10; i++) do_read(7'(i), 32'h0);
    do_read(7'd10, 32'h10A);
    do_read(7'd11, 32'h10B);
    do_read(7'd127, 32'h17F);
    end_req;
    drain;
  endtask

  task automatic test_same_edge;
    do_fill(2'd2, 32'h41, 128, 1'b1);
    do_read(7'd3, 32'h41);
    do_read(7'd0, 32'h41);
    do_read(7'd127, 32'h41);
    end_req;
    drain;
  endtask

  task automatic test_depth100;
    @(negedge clk);
    sel = 1'b1;
    do_fill(2'd1, 32'h0, 100, 1'b0);
    do_write(7'd110, 32'hFFFFFFFF, 4'b1111);
    end_req;
    checks++;
    if (addr_err_m !== 1'b1) begin
      errors++;
      $display("FAIL oob_write_err: addr_err=%b, expected 1", addr_err_m);
    end
    @(negedge clk);
    checks++;
    if (addr_err_m !== 1'b0 || rd_valid_m !== 1'b0) begin
      errors++;
      $display("FAIL oob_write_pulse: addr_err=%b rd_valid=%b, expected 0 0", addr_err_m, rd_valid_m);
    end
    do_read(7'd120, 32'h0);
    end_req;
    checks++;
    if (addr_err_m !== 1'b1) begin
      errors++;
      $display("FAIL oob_read_err: addr_err=%b, expected 1", addr_err_m);
    end
    drain;
    do_read(7'd10, 32'd10);
    do_read(7'd46, 32'd46);
    do_read(7'd99, 32'd99);
    end_req;
    checks++;
    if (addr_err_m !== 1'b0) begin
      errors++;
      $display("FAIL inrange_err: addr_err=%b, expected 0", addr_err_m);
    end
    drain;
    @(negedge clk);
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fill_index;
    test_back_to_back;
    test_byte_enable;
    test_fill_offset_reset;
    test_same_edge;
    test_depth100;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
